imem_access_ctrl: RTL and testbench

- Sequences and arbitrates the single-port instruction memory between two requesters: the CPU fetch stage (read) and the program loader (write).
- After reset the block holds the CPU in a boot phase, so the loader can fill the program image first; it then releases the core.
- In the run phase it shares the port cycle-by-cycle, checks word alignment and range, and returns registered fetch data.
- Sits between the PC/fetch logic and the instruction memory array.

---
 rtl/imem_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_imem_access_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_access_ctrl.sv
// imem_access_ctrl: boot/run sequencing and per-cycle arbitration of a single-port
// instruction memory between the CPU fetch stage and the program loader.
// Optional macro IMEM_WRITE_PROTECT_EN: every loader write is rejected once in RUN.
module imem_access_ctrl #(
  parameter int unsigned DEPTH        = 512,
  parameter int unsigned IDX_W        = 9,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_done,
  input  logic             fetch_req,
  input  logic [31:0]      fetch_addr,
  output logic             fetch_gnt,
  output logic             fetch_valid,
  output logic [31:0]      fetch_rdata,
  output logic             fetch_err,
  output logic             stall,
  input  logic             load_req,
  input  logic [31:0]      load_addr,
  input  logic [31:0]      load_wdata,
  output logic             load_gnt,
  output logic             load_err,
  output logic [IDX_W-1:0] mem_idx,
  output logic             mem_we,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             fetch_err_q, fetch_err_d;
  logic [31:0]      fetch_rdata_q, fetch_rdata_d;
  logic             load_err_q, load_err_d;
  logic             fetch_bad_s;
  logic             load_bad_s;

  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
  endfunction

  // Arbitration, memory port steering, starvation counter and next state.
  always_comb begin
    state_d       = state_q;
    starve_cnt_d  = starve_cnt_q;
    fetch_gnt     = 1'b0;
    load_gnt      = 1'b0;
    fetch_bad_s   = addr_bad(fetch_addr);
    load_bad_s    = addr_bad(load_addr);
    mem_idx       = '0;
    mem_we        = 1'b0;
    mem_wdata     = 32'h0000_0000;
    fetch_valid_d = 1'b0;
    fetch_err_d   = 1'b0;
    fetch_rdata_d = fetch_rdata_q;
    load_err_d    = 1'b0;

    case (state_q)
      ST_BOOT: begin
        load_gnt     = load_req;
        starve_cnt_d = '0;
        if (load_done) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_BOOT;
        end
      end
      ST_RUN: begin
`ifdef IMEM_WRITE_PROTECT_EN
        // Loads never touch memory here, so both sides are granted together.
        load_gnt     = load_req;
        fetch_gnt    = fetch_req;
        load_bad_s   = 1'b1;
        starve_cnt_d = '0;
`else
        if (fetch_req && (starve_cnt_q == CNT_MAX)) begin
          fetch_gnt = 1'b1;
        end else begin
          load_gnt  = load_req;
          fetch_gnt = fetch_req && !load_req;
        end
        if (!fetch_req || fetch_gnt) begin
          starve_cnt_d = '0;
        end else if (load_gnt && (starve_cnt_q != CNT_MAX)) begin
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else begin
          starve_cnt_d = starve_cnt_q;
        end
`endif
      end
      default: begin
        state_d      = ST_BOOT;
        starve_cnt_d = '0;
      end
    endcase

    if (load_gnt && !load_bad_s) begin
      mem_idx   = load_addr[IDX_W+1:2];
      mem_we    = 1'b1;
      mem_wdata = load_wdata;
    end else if (fetch_gnt && !fetch_bad_s) begin
      mem_idx = fetch_addr[IDX_W+1:2];
    end else begin
      mem_idx = '0;
    end

    if (fetch_gnt) begin
      fetch_valid_d = 1'b1;
      fetch_err_d   = fetch_bad_s;
      fetch_rdata_d = fetch_bad_s ? 32'h0000_0000 : mem_rdata;
    end else begin
      fetch_valid_d = 1'b0;
      fetch_err_d   = 1'b0;
    end

    load_err_d = load_gnt && load_bad_s;
  end

  // State register and registered responses; reset drops any in-flight fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_BOOT;
      starve_cnt_q  <= '0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      fetch_rdata_q <= 32'h0000_0000;
      load_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      fetch_rdata_q <= fetch_rdata_d;
      load_err_q    <= load_err_d;
    end
  end

  assign stall       = fetch_req && !fetch_gnt;
  assign fetch_valid = fetch_valid_q;
  assign fetch_err   = fetch_err_q;
  assign fetch_rdata = fetch_rdata_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Bench for imem_access_ctrl: directed vector table, hand sequences for the
// multi-cycle corners, and random traffic against a rule-level reference model.
module tb_imem_access_ctrl;

  localparam int unsigned DEPTH        = 512;
  localparam int unsigned IDX_W        = 9;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int          NV           = 10;

  logic             clk, rst, load_done;
  logic             fetch_req, fetch_gnt, fetch_valid, fetch_err, stall;
  logic [31:0]      fetch_addr, fetch_rdata;
  logic             load_req, load_gnt, load_err;
  logic [31:0]      load_addr, load_wdata;
  logic [IDX_W-1:0] mem_idx;
  logic             mem_we;
  logic [31:0]      mem_wdata, mem_rdata;

  logic [31:0] imem [DEPTH];
  logic        mem_ready;

  int n_tests, n_fail;

  // Reference model state
  bit          m_run;
  int          m_starve;
  logic [31:0] m_mem [DEPTH];
  logic        e_fv, e_ferr, e_lerr;
  logic [31:0] e_frd;

  typedef struct {
    logic fgnt, lgnt, stall, fv, ferr, lerr, we;
    logic [31:0] frd;
  } obs_t;

  typedef struct {
    logic        ld, fr;
    logic [31:0] fa;
    logic        lr;
    logic [31:0] la, lw;
    logic        fgnt, lgnt, stall, fv, ferr;
    logic [31:0] frd;
    logic        lerr, we;
  } vec_t;

  imem_access_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst), .load_done(load_done),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .stall(stall), .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
    .load_gnt(load_gnt), .load_err(load_err), .mem_idx(mem_idx), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A00_0000 | 32'(i);
  endfunction

  // Instruction memory array seen by the DUT.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < int'(DEPTH); i++) imem[i] <= init_word(i);
    end else if (mem_we) begin
      imem[mem_idx] <= mem_wdata;
    end
  end
  assign mem_rdata = imem[mem_idx];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_starve = 0;
    e_fv = 1'b0; e_ferr = 1'b0; e_lerr = 1'b0; e_frd = 32'h0;
  endtask

  // One clock cycle: drive, sample at the falling edge, compare with the model, advance.
  task automatic step(input logic ld, input logic fr, input logic [31:0] fa,
                      input logic lr, input logic [31:0] la, input logic [31:0] lw,
                      output obs_t o);
    logic fbad, lbad, gf, gl, ewe;
    int   fw, lwi, eidx;
    load_done = ld; fetch_req = fr; fetch_addr = fa;
    load_req = lr; load_addr = la; load_wdata = lw;
    #4;
    fw   = int'(fa >> 2);
    lwi  = int'(la >> 2);
    fbad = (fa[1:0] != 2'b00) || ((fa >> 2) >= 32'(DEPTH));
    lbad = (la[1:0] != 2'b00) || ((la >> 2) >= 32'(DEPTH));
    if (!m_run) begin
      gf = 1'b0; gl = lr;
    end else begin
`ifdef IMEM_WRITE_PROTECT_EN
      gf = fr; gl = lr; lbad = 1'b1;
`else
      if (fr && m_starve == int'(STARVE_LIMIT)) begin
        gf = 1'b1; gl = 1'b0;
      end else begin
        gl = lr; gf = fr && !lr;
      end
`endif
    end
    ewe  = gl && !lbad;
    eidx = ewe ? lwi : ((gf && !fbad) ? fw : 0);

    check("fetch_gnt", {31'b0, fetch_gnt}, {31'b0, gf});
    check("load_gnt", {31'b0, load_gnt}, {31'b0, gl});
    check("stall", {31'b0, stall}, {31'b0, fr && !gf});
    check("mem_we", {31'b0, mem_we}, {31'b0, ewe});
    check("mem_idx", 32'(mem_idx), 32'(eidx));
    if (ewe) check("mem_wdata", mem_wdata, lw);
    check("fetch_valid", {31'b0, fetch_valid}, {31'b0, e_fv});
    if (e_fv) begin
      check("fetch_err", {31'b0, fetch_err}, {31'b0, e_ferr});
      check("fetch_rdata", fetch_rdata, e_frd);
    end
    check("load_err", {31'b0, load_err}, {31'b0, e_lerr});

    o.fgnt = fetch_gnt; o.lgnt = load_gnt; o.stall = stall; o.fv = fetch_valid;
    o.ferr = fetch_err; o.lerr = load_err; o.we = mem_we; o.frd = fetch_rdata;

    if (gf) e_frd = fbad ? 32'h0 : m_mem[fw];
    e_fv   = gf;
    e_ferr = gf && fbad;
    e_lerr = gl && lbad;
    if (ewe) m_mem[lwi] = lw;
`ifndef IMEM_WRITE_PROTECT_EN
    if (m_run) begin
      if (!fr || gf) m_starve = 0;
      else if (gl && m_starve < int'(STARVE_LIMIT)) m_starve++;
    end
`endif
    if (ld) m_run = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_fetch_addr();
    int r;
    r = int'($urandom_range(9));
    if (r == 0) return 32'($urandom_range(63)) * 32'd4 + 32'($urandom_range(3, 1));
    if (r == 1) return 32'(DEPTH) * 32'd4 + 32'($urandom_range(1000)) * 32'd4;
    return 32'($urandom_range(63)) * 32'd4;
  endfunction

  function automatic logic [31:0] rand_load_addr();
    int r;
    r = int'($urandom_range(9));
    if (r == 0) return 32'($urandom_range(63, 16)) * 32'd4 + 32'($urandom_range(3, 1));
    if (r == 1) return 32'(DEPTH) * 32'd4 + 32'($urandom_range(1000)) * 32'd4;
    return 32'($urandom_range(63, 16)) * 32'd4;
  endfunction

  vec_t vecs [NV];
  obs_t o;
  logic pf, pl;
  logic [31:0] pfa, pla, plw;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h4, 1'b1, 32'h0, 32'hAC41_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h4, 32'h8C85_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8C85_0000, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h6, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'h800, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h2, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};

    n_tests = 0; n_fail = 0; mem_ready = 1'b0;
    rst = 1'b0; load_done = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h4;
    load_req = 1'b0; load_addr = 32'h0; load_wdata = 32'h0;
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = init_word(i);
    model_reset();

    #2;
    check("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    check("rst_fetch_rdata", fetch_rdata, 32'h0);
    check("rst_fetch_err", {31'b0, fetch_err}, 32'h0);
    check("rst_load_err", {31'b0, load_err}, 32'h0);
    check("rst_fetch_gnt", {31'b0, fetch_gnt}, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h1);
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    rst = 1'b1;

    // Boot path, bad fetches, bad load
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].ld, vecs[i].fr, vecs[i].fa, vecs[i].lr, vecs[i].la, vecs[i].lw, o);
      check($sformatf("tbl%0d_fgnt", i), {31'b0, o.fgnt}, {31'b0, vecs[i].fgnt});
      check($sformatf("tbl%0d_lgnt", i), {31'b0, o.lgnt}, {31'b0, vecs[i].lgnt});
      check($sformatf("tbl%0d_stall", i), {31'b0, o.stall}, {31'b0, vecs[i].stall});
      check($sformatf("tbl%0d_fv", i), {31'b0, o.fv}, {31'b0, vecs[i].fv});
      check($sformatf("tbl%0d_lerr", i), {31'b0, o.lerr}, {31'b0, vecs[i].lerr});
      check($sformatf("tbl%0d_we", i), {31'b0, o.we}, {31'b0, vecs[i].we});
      if (vecs[i].fv) begin
        check($sformatf("tbl%0d_ferr", i), {31'b0, o.ferr}, {31'b0, vecs[i].ferr});
        check($sformatf("tbl%0d_frd", i), o.frd, vecs[i].frd);
      end
    end

    // Starvation: both requesters held high
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 1'b1, 32'h0, 1'b1, 32'h100 + 32'(k) * 32'd4, 32'h1234_0000 | 32'(k), o);
`ifdef IMEM_WRITE_PROTECT_EN
      check("starve_fgnt", {31'b0, o.fgnt}, 32'h1);
`else
      check("starve_fgnt", {31'b0, o.fgnt}, {31'b0, (k % 5) == 4});
`endif
    end

`ifdef IMEM_WRITE_PROTECT_EN
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'hFFFF_FFFF, o);
    check("wp_lgnt", {31'b0, o.lgnt}, 32'h1);
    check("wp_we", {31'b0, o.we}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, o);
    check("wp_lerr", {31'b0, o.lerr}, 32'h1);
    step(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, o);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, o);
    check("wp_fv", {31'b0, o.fv}, 32'h1);
    check("wp_frd", o.frd, 32'hAC41_0000);
`endif

    // Random traffic obeying the hold-until-grant protocol
    pf = 1'b0; pl = 1'b0; pfa = 32'h0; pla = 32'h0; plw = 32'h0;
    for (int c = 0; c < 400; c++) begin
      if (!pf && $urandom_range(99) < 60) begin pf = 1'b1; pfa = rand_fetch_addr(); end
      if (!pl && $urandom_range(99) < 50) begin pl = 1'b1; pla = rand_load_addr(); plw = $urandom; end
      step($urandom_range(19) == 0, pf, pfa, pl, pla, plw, o);
      if (o.fgnt) pf = 1'b0;
      if (o.lgnt) pl = 1'b0;
    end

    // Reset in the cycle of a fetch grant
    load_done = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h4; load_req = 1'b0;
    #4;
    check("midrst_fgnt", {31'b0, fetch_gnt}, 32'h1);
    rst = 1'b0;
    #1;
    check("midrst_fv_async", {31'b0, fetch_valid}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    check("midrst_fv", {31'b0, fetch_valid}, 32'h0);
    check("midrst_boot_fgnt", {31'b0, fetch_gnt}, 32'h0);
    check("midrst_boot_stall", {31'b0, stall}, 32'h1);
    rst = 1'b1;
    step(1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, o);
    check("reboot_fgnt", {31'b0, o.fgnt}, 32'h0);
    step(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, o);
    check("rerun_fgnt", {31'b0, o.fgnt}, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, o);
    check("rerun_fv", {31'b0, o.fv}, 32'h1);
    check("rerun_frd", o.frd, 32'h8C85_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
